// File: rtl/rf_pkg.sv
// rf_pkg
// Shared definitions for the register file and its busy scoreboard.
//   aw_of / cw_of : address width and busy-count width for a given depth
//   AW / CW       : those widths for the default 32-entry file
//   rf_addr_t     : register index type for the default depth
//   ZERO_ADDR     : index of the hard-wired zero register
package rf_pkg;

  localparam int DEFAULT_DEPTH = 32;

  function automatic int aw_of(input int depth);
    return $clog2(depth);
  endfunction

  // The count has to reach DEPTH itself, hence depth+1.
  function automatic int cw_of(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int AW = aw_of(DEFAULT_DEPTH);
  localparam int CW = cw_of(DEFAULT_DEPTH);

  typedef logic [AW-1:0] rf_addr_t;

  localparam rf_addr_t ZERO_ADDR = '0;

endpackage

// File: rtl/register.sv
// register
// Plain N-bit storage register with load enable.
//   clk, rst : clock and synchronous active-high reset (clears to 0)
//   ena      : load d at the next rising edge
//   d, q     : data in / registered data out
module register #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  logic [N-1:0] data_d;
  logic [N-1:0] data_q;

  // Next value: hold unless a load is requested.
  always_comb begin
    data_d = data_q;
    if (ena) begin
      data_d = d;
    end
  end

  // Reset wins over a load in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/register_file_scoreboard_reg_scoreboard.sv
// reg_scoreboard
// Per-register busy bits plus a registered population count.
//   clk, rst           : clock and synchronous active-high reset
//   wr_ena, wr_addr    : writeback; releases busy[wr_addr]
//   rsv_ena, rsv_addr  : reservation; sets busy[rsv_addr]
//   flush              : clears every busy bit, drops a same-cycle reserve
//   busy               : current busy vector
//   busy_count         : popcount of busy, updated with the vector
module reg_scoreboard
  import rf_pkg::*;
#(
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 1,
  localparam int AW      = aw_of(DEPTH),
  localparam int CW      = cw_of(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_ena,
  input  logic [AW-1:0]    wr_addr,
  input  logic             rsv_ena,
  input  logic [AW-1:0]    rsv_addr,
  input  logic             flush,
  output logic [DEPTH-1:0] busy,
  output logic [CW-1:0]    busy_count
);

  logic [DEPTH-1:0] busy_d;
  logic [DEPTH-1:0] busy_q;
  logic [CW-1:0]    count_d;
  logic [CW-1:0]    count_q;

  // Next busy vector. Release is applied before reserve so that a
  // reserve and a release of the same register leave it busy: the
  // reserve belongs to a newer writer of that register.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (wr_ena) begin
        busy_d[wr_addr] = 1'b0;
      end
      if (rsv_ena) begin
        busy_d[rsv_addr] = 1'b1;
      end
    end
    if (ZERO_REG != 0) begin
      busy_d[0] = 1'b0;
    end
  end

  // The count is taken from the next-state vector so it lines up with
  // the busy bits after the same edge.
  always_comb begin
    count_d = '0;
    for (int k = 0; k < DEPTH; k++) begin
      count_d = count_d + CW'(busy_d[k]);
    end
  end

  // Busy bits and their count, cleared together on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign busy       = busy_q;
  assign busy_count = count_q;

endmodule

// File: rtl/register_file_scoreboard.sv
// register_file_scoreboard
// Multi-port integer register file with optional write-to-read bypass and
// an integrated busy scoreboard for hazard detection.
//   clk, rst            : clock and synchronous active-high reset
//   wr_ena/addr/data    : writeback port; also releases the register
//   rsv_ena, rsv_addr   : reserve a destination register at issue
//   flush               : clear all busy bits (data untouched)
//   rd_addr[i]          : read index for port i
//   rd_data[i]          : combinational read data for port i
//   rd_busy[i]          : combinational pending flag for port i
//   busy_count          : registered number of busy registers
module register_file_scoreboard
  import rf_pkg::*;
#(
  parameter int N        = 32,
  parameter int DEPTH    = 32,
  parameter int RD_PORTS = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = aw_of(DEPTH),
  localparam int CW      = cw_of(DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_ena,
  input  logic [AW-1:0]                wr_addr,
  input  logic [N-1:0]                 wr_data,
  input  logic                         rsv_ena,
  input  logic [AW-1:0]                rsv_addr,
  input  logic                         flush,
  input  logic [RD_PORTS-1:0][AW-1:0]  rd_addr,
  output logic [RD_PORTS-1:0][N-1:0]   rd_data,
  output logic [RD_PORTS-1:0]          rd_busy,
  output logic [CW-1:0]                busy_count
);

  logic [N-1:0]     regs [DEPTH];
  logic [DEPTH-1:0] busy;

  function automatic logic is_zero(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == AW'(ZERO_ADDR));
  endfunction

  // One storage register per entry; the zero register has no storage
  // at all when it is hard-wired.
  for (genvar k = 0; k < DEPTH; k++) begin : g_reg
    if (ZERO_REG != 0 && k == 0) begin : g_zero
      assign regs[k] = '0;
    end else begin : g_store
      logic ena;
      assign ena = wr_ena & (wr_addr == AW'(k));
      register #(.N(N)) u_reg (
        .clk (clk),
        .rst (rst),
        .ena (ena),
        .d   (wr_data),
        .q   (regs[k])
      );
    end
  end

  reg_scoreboard #(
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .wr_ena     (wr_ena),
    .wr_addr    (wr_addr),
    .rsv_ena    (rsv_ena),
    .rsv_addr   (rsv_addr),
    .flush      (flush),
    .busy       (busy),
    .busy_count (busy_count)
  );

  // Read muxes. A matching same-cycle write forwards its data and hides
  // the busy bit it is about to clear, so a dependent instruction can
  // proceed in the writeback cycle. The zero register overrides both.
  always_comb begin
    for (int i = 0; i < RD_PORTS; i++) begin
      rd_data[i] = regs[rd_addr[i]];
      rd_busy[i] = busy[rd_addr[i]];
      if (BYPASS != 0 && wr_ena && wr_addr == rd_addr[i]) begin
        rd_data[i] = wr_data;
        rd_busy[i] = 1'b0;
      end
      if (is_zero(rd_addr[i])) begin
        rd_data[i] = '0;
        rd_busy[i] = 1'b0;
      end
    end
  end

endmodule
